sbox_gen_ctrl: RTL and testbench



---
 rtl/sbox_gen_pkg.sv | 16 +
 rtl/sbox_gen_cnt.sv | 25 ++
 rtl/sbox_gen_ctrl.sv | 100 ++++++++++
 tb/tb_sbox_gen_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_gen_pkg.sv
// sbox_gen_pkg: shared state encoding and S-box geometry for the generation controller
package sbox_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_FILL  = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_DONE  = 3'd4;
  localparam state_t S_ERR   = 3'd5;

  localparam int SBOX_SIZE = 256;
  localparam int SBOX_AW   = 8;

endpackage

// File: rtl/sbox_gen_cnt.sv
// sbox_gen_cnt: loadable up-counter with optional saturation and terminal-count compare
module sbox_gen_cnt #(
  parameter int W   = 8,
  parameter int TC  = 0,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // load has priority; with SAT set the count parks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc && !(SAT && &cnt)) cnt <= cnt + 1'b1;
  end

  assign tc = cnt == W'(TC);

endmodule

// File: rtl/sbox_gen_ctrl.sv
// sbox_gen_ctrl: sequences the chaotic S-box datapath from pipeline fill to 256 unique writes
module sbox_gen_ctrl
  import sbox_gen_pkg::*;
#(
  parameter int PIPE_DEPTH  = 3,
  parameter int MAX_SAMPLES = 4096,
  parameter int SAMPLE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                seen_flag,
  output logic                enable_read,
  output logic                enable_extract,
  output logic                clear_seen,
  output logic                wr_en,
  output logic [SBOX_AW-1:0]  wr_addr,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [SAMPLE_W-1:0] sample_cnt
);

  localparam int FILL_W = $clog2(PIPE_DEPTH + 1);

  state_t state, next;
  logic start_ok, unique_c, complete, fill_tc, sample_tc;
  logic [FILL_W-1:0] unused_fill_cnt;

  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign unique_c = state == S_RUN && !seen_flag;
  assign complete = unique_c && wr_addr == SBOX_AW'(SBOX_SIZE - 1);
  assign wr_en    = unique_c;

  // counts FILL cycles so RUN begins exactly when the first candidate leaves the mixer
  sbox_gen_cnt #(.W(FILL_W), .TC(PIPE_DEPTH - 1), .SAT(1'b1)) u_fill_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val ('0),
    .inc      (state == S_FILL),
    .cnt      (unused_fill_cnt),
    .tc       (fill_tc)
  );

  // candidates examined this run; terminal count flags the last budgeted sample
  sbox_gen_cnt #(.W(SAMPLE_W), .TC(MAX_SAMPLES - 1), .SAT(1'b1)) u_sample_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val ('0),
    .inc      (state == S_RUN),
    .cnt      (sample_cnt),
    .tc       (sample_tc)
  );

  // next state; completion outranks budget exhaustion, unknown encodings recover to IDLE
  always_comb begin
    next = start_ok                        ? S_CLEAR :
           state > S_ERR                   ? S_IDLE  :
           state == S_CLEAR                ? S_FILL  :
           (state == S_FILL && fill_tc)    ? S_RUN   :
           state != S_RUN                  ? state   :
           complete                        ? S_DONE  :
           sample_tc                       ? S_ERR   : S_RUN;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= next;
  end

  // outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_read    <= 1'b0;
      enable_extract <= 1'b0;
      clear_seen     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      enable_read    <= next == S_FILL || next == S_RUN;
      enable_extract <= next == S_FILL || next == S_RUN;
      clear_seen     <= next == S_CLEAR;
      busy           <= next == S_CLEAR || next == S_FILL || next == S_RUN;
      done           <= next == S_DONE;
      error          <= next == S_ERR;
    end
  end

  // write pointer advances only after a unique byte is written; the final write wraps it to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_addr <= '0;
    else if (start_ok) wr_addr <= '0;
    else if (unique_c) wr_addr <= wr_addr + 1'b1;
  end

endmodule

// File: tb/tb_sbox_gen_ctrl.sv
// tb_sbox_gen_ctrl: directed checks of run sequencing, duplicate skipping, budget abort and reset
module tb_sbox_gen_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic start = 0, seen = 0, en_rd, en_ex, clr, wr_en, busy, done, error;
  logic [7:0] wr_addr;
  logic [15:0] scnt;

  logic start_e = 0, seen_e = 0, en_rd_e, en_ex_e, clr_e, wr_en_e, busy_e, done_e, error_e;
  logic [7:0] wr_addr_e;
  logic [15:0] scnt_e;

  logic start_b = 0, seen_b = 0, en_rd_b, en_ex_b, clr_b, wr_en_b, busy_b, done_b, error_b;
  logic [7:0] wr_addr_b;
  logic [15:0] scnt_b;

  sbox_gen_ctrl #(.PIPE_DEPTH(3), .MAX_SAMPLES(4096), .SAMPLE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .seen_flag(seen),
    .enable_read(en_rd), .enable_extract(en_ex), .clear_seen(clr), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done), .error(error), .sample_cnt(scnt)
  );

  sbox_gen_ctrl #(.PIPE_DEPTH(3), .MAX_SAMPLES(300), .SAMPLE_W(16)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .seen_flag(seen_e),
    .enable_read(en_rd_e), .enable_extract(en_ex_e), .clear_seen(clr_e), .wr_en(wr_en_e),
    .wr_addr(wr_addr_e), .busy(busy_e), .done(done_e), .error(error_e), .sample_cnt(scnt_e)
  );

  sbox_gen_ctrl #(.PIPE_DEPTH(3), .MAX_SAMPLES(256), .SAMPLE_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seen_flag(seen_b),
    .enable_read(en_rd_b), .enable_extract(en_ex_b), .clear_seen(clr_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .busy(busy_b), .done(done_b), .error(error_b), .sample_cnt(scnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_en_rd"}, en_rd, 0);
    chk({tag, "_en_ex"}, en_ex, 0);
    chk({tag, "_clr"}, clr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_scnt"}, scnt, 0);
  endtask

  // start pulse at the current negedge, then a full run with every candidate unique
  task automatic run_all_unique(input string tag);
    start = 1;
    nc();
    start = 0;
    #1;
    chk({tag, "_clear_pulse"}, clr, 1);
    chk({tag, "_clear_busy"}, busy, 1);
    chk({tag, "_clear_done"}, done, 0);
    chk({tag, "_clear_en_rd"}, en_rd, 0);
    nc();
    chk({tag, "_fill_en_rd"}, en_rd, 1);
    chk({tag, "_fill_en_ex"}, en_ex, 1);
    chk({tag, "_fill_clr"}, clr, 0);
    chk({tag, "_fill_scnt"}, scnt, 0);
    nc();
    nc();
    chk({tag, "_fill_wr_en"}, wr_en, 0);
    nc();
    for (int i = 0; i < 256; i++) begin
      seen = 0;
      #1;
      chk({tag, "_run_wr_en"}, wr_en, 1);
      chk({tag, "_run_wr_addr"}, wr_addr, i);
      chk({tag, "_run_scnt"}, scnt, i);
      nc();
    end
    #1;
    chk({tag, "_end_done"}, done, 1);
    chk({tag, "_end_error"}, error, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_en_rd"}, en_rd, 0);
    chk({tag, "_end_wr_en"}, wr_en, 0);
    chk({tag, "_end_wr_addr"}, wr_addr, 0);
    chk({tag, "_end_scnt"}, scnt, 256);
    nc();
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_scnt"}, scnt, 256);
  endtask

  initial begin
    #1;
    chk_main_zero("reset");
    chk("reset_e_busy", busy_e, 0);
    chk("reset_b_error", error_b, 0);
    nc();
    nc();
    rst = 1;
    nc();
    chk("idle_busy", busy, 0);
    chk("idle_wr_en", wr_en, 0);

    run_all_unique("uniq");

    start = 1;
    nc();
    start = 0;
    #1;
    chk("restart_done_drop", done, 0);
    chk("restart_clear", clr, 1);
    nc();
    nc();
    nc();
    nc();
    for (int j = 0; j < 512; j++) begin
      seen  = (j % 2 == 0);
      start = (j == 10);
      #1;
      chk("alt_wr_en", wr_en, !seen);
      chk("alt_wr_addr", wr_addr, j / 2);
      if (j == 11) begin
        chk("alt_start_ignored_clr", clr, 0);
        chk("alt_start_ignored_busy", busy, 1);
      end
      nc();
    end
    start = 0;
    seen  = 0;
    #1;
    chk("alt_done", done, 1);
    chk("alt_scnt", scnt, 512);
    chk("alt_wr_addr_end", wr_addr, 0);
    nc();

    run_all_unique("again");

    start = 1;
    nc();
    start = 0;
    for (int c = 1; c < 10; c++) nc();
    #1;
    chk("midrun_wr_addr", wr_addr, 5);
    chk("midrun_busy", busy, 1);
    #1;
    rst = 0;
    #1;
    chk_main_zero("async_rst");
    nc();
    rst = 1;
    nc();
    start = 1;
    nc();
    start = 0;
    #1;
    chk("post_rst_clear", clr, 1);
    nc();
    chk("post_rst_clear_once", clr, 0);
    chk("post_rst_fill", en_rd, 1);

    start_e = 1;
    nc();
    start_e = 0;
    nc();
    nc();
    nc();
    nc();
    for (int k = 0; k < 300; k++) begin
      seen_e = (k >= 100);
      #1;
      chk("budget_wr_en", wr_en_e, k < 100);
      if (k == 299) chk("budget_last_busy", busy_e, 1);
      nc();
    end
    seen_e = 0;
    #1;
    chk("budget_error", error_e, 1);
    chk("budget_done", done_e, 0);
    chk("budget_wr_addr", wr_addr_e, 100);
    chk("budget_scnt", scnt_e, 300);
    chk("budget_en_rd", en_rd_e, 0);
    chk("budget_busy", busy_e, 0);
    nc();
    chk("budget_err_no_wr", wr_en_e, 0);
    chk("budget_err_hold", error_e, 1);

    start_b = 1;
    nc();
    start_b = 0;
    nc();
    nc();
    nc();
    nc();
    for (int k = 0; k < 256; k++) begin
      seen_b = 0;
      #1;
      chk("tie_wr_en", wr_en_b, 1);
      nc();
    end
    #1;
    chk("tie_done", done_b, 1);
    chk("tie_error", error_b, 0);
    chk("tie_scnt", scnt_b, 256);
    chk("tie_wr_addr", wr_addr_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
